// File: rtl/soc_obi_pkg.sv
// soc_obi_pkg: shared types, default address map and helpers for the OBI crossbar
package soc_obi_pkg;
  typedef struct packed {
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } addr_rule_t;
  localparam addr_rule_t [2:0] DEF_MAP = '{
    '{start_addr: 32'h1A10_0000, end_addr: 32'h1A11_FFFF},
    '{start_addr: 32'h0010_0000, end_addr: 32'h001F_FFFF},
    '{start_addr: 32'h0000_0000, end_addr: 32'h000F_FFFF}
  };
  localparam logic [95:0] DEF_START_ADDR = {DEF_MAP[2].start_addr, DEF_MAP[1].start_addr, DEF_MAP[0].start_addr};
  localparam logic [95:0] DEF_END_ADDR = {DEF_MAP[2].end_addr, DEF_MAP[1].end_addr, DEF_MAP[0].end_addr};
  localparam logic [31:0] DEF_ERR_RDATA = 32'hBADA_CCE5;
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/soc_obi_rr_arb.sv
// soc_obi_rr_arb: round-robin arbiter whose pointer moves past the winner only on a handshake
module soc_obi_rr_arb
  import soc_obi_pkg::*;
#(
  parameter int NB_REQ = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NB_REQ-1:0] req,
  input  logic              hs,
  output logic [NB_REQ-1:0] gnt
);
  localparam int IW = id_width(NB_REQ);
  logic [IW-1:0] ptr, idx;
  always_comb begin
    idx = '0;
    for (int k = 2 * NB_REQ - 1; k >= 0; k--)
      if (k >= int'(ptr) && req[k % NB_REQ]) idx = IW'(k % NB_REQ);
    for (int i = 0; i < NB_REQ; i++) gnt[i] = |req && idx == IW'(i);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (hs) ptr <= IW'((int'(idx) + 1) % NB_REQ);
endmodule

// File: rtl/soc_obi_xbar.sv
// soc_obi_xbar: OBI request/grant crossbar with per-slave round-robin, in-order response routing and decode errors
module soc_obi_xbar
  import soc_obi_pkg::*;
#(
  parameter int NB_MASTER = 3,
  parameter int NB_SLAVE = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [NB_SLAVE*ADDR_WIDTH-1:0] START_ADDR = DEF_START_ADDR,
  parameter logic [NB_SLAVE*ADDR_WIDTH-1:0] END_ADDR = DEF_END_ADDR,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA = DEF_ERR_RDATA
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [NB_MASTER-1:0]                      m_req_i,
  input  logic [NB_MASTER-1:0]                      m_we_i,
  input  logic [NB_MASTER-1:0][ADDR_WIDTH-1:0]      m_addr_i,
  input  logic [NB_MASTER-1:0][DATA_WIDTH/8-1:0]    m_be_i,
  input  logic [NB_MASTER-1:0][DATA_WIDTH-1:0]      m_wdata_i,
  output logic [NB_MASTER-1:0]                      m_gnt_o,
  output logic [NB_MASTER-1:0]                      m_rvalid_o,
  output logic [NB_MASTER-1:0]                      m_err_o,
  output logic [NB_MASTER-1:0][DATA_WIDTH-1:0]      m_rdata_o,
  output logic [NB_SLAVE-1:0]                       s_req_o,
  output logic [NB_SLAVE-1:0]                       s_we_o,
  output logic [NB_SLAVE-1:0][ADDR_WIDTH-1:0]       s_addr_o,
  output logic [NB_SLAVE-1:0][DATA_WIDTH/8-1:0]     s_be_o,
  output logic [NB_SLAVE-1:0][DATA_WIDTH-1:0]       s_wdata_o,
  input  logic [NB_SLAVE-1:0]                       s_gnt_i,
  input  logic [NB_SLAVE-1:0]                       s_rvalid_i,
  input  logic [NB_SLAVE-1:0][DATA_WIDTH-1:0]       s_rdata_i,
  output logic [NB_SLAVE-1:0]                       s_idle_o
);
  localparam int IW = id_width(NB_MASTER);
  localparam int TW = $clog2(NB_SLAVE + 1);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = id_width(MAX_OUTSTANDING);
  localparam logic [CW-1:0] MO = CW'(MAX_OUTSTANDING);
  logic [NB_MASTER-1:0][TW-1:0] tgt, cur;
  logic [NB_MASTER-1:0][CW-1:0] cnt;
  logic [NB_MASTER-1:0] elig;
  logic [NB_SLAVE:0][NB_MASTER-1:0] sreq, win;
  logic [NB_SLAVE:0][IW-1:0] widx;
  logic [NB_SLAVE:0] hs;
  logic [NB_SLAVE-1:0][CW-1:0] fcnt;
  logic [NB_SLAVE-1:0][IW-1:0] head;
  logic [NB_SLAVE-1:0] pop;
  logic err_v;
  logic [IW-1:0] err_id;
  // lowest matching region wins; a master may only add to its in-flight set at the same target
  always_comb begin
    for (int i = 0; i < NB_MASTER; i++) begin
      tgt[i] = TW'(NB_SLAVE);
      for (int j = NB_SLAVE - 1; j >= 0; j--)
        if (m_addr_i[i] >= START_ADDR[j*ADDR_WIDTH +: ADDR_WIDTH] && m_addr_i[i] <= END_ADDR[j*ADDR_WIDTH +: ADDR_WIDTH])
          tgt[i] = TW'(j);
      elig[i] = rst_n && m_req_i[i] && cnt[i] < MO && (cnt[i] == '0 || tgt[i] == cur[i]);
    end
  end
  always_comb
    for (int j = 0; j <= NB_SLAVE; j++)
      for (int i = 0; i < NB_MASTER; i++) sreq[j][i] = elig[i] && tgt[i] == TW'(j);
  for (genvar j = 0; j <= NB_SLAVE; j++) begin : g_arb
    soc_obi_rr_arb #(.NB_REQ(NB_MASTER)) u_arb (
      .clk  (clk),
      .rst_n(rst_n),
      .req  (sreq[j]),
      .hs   (hs[j]),
      .gnt  (win[j])
    );
  end
  always_comb
    for (int j = 0; j <= NB_SLAVE; j++) begin
      widx[j] = '0;
      for (int i = 0; i < NB_MASTER; i++) if (win[j][i]) widx[j] = IW'(i);
    end
  always_comb begin
    for (int j = 0; j < NB_SLAVE; j++) begin
      s_req_o[j] = |sreq[j] && fcnt[j] != MO;
      s_we_o[j] = m_we_i[widx[j]];
      s_addr_o[j] = m_addr_i[widx[j]];
      s_be_o[j] = m_be_i[widx[j]];
      s_wdata_o[j] = m_wdata_i[widx[j]];
      hs[j] = s_req_o[j] && s_gnt_i[j];
    end
    hs[NB_SLAVE] = |sreq[NB_SLAVE];
  end
  always_comb
    for (int i = 0; i < NB_MASTER; i++) begin
      m_gnt_o[i] = 1'b0;
      m_err_o[i] = err_v && err_id == IW'(i);
      m_rvalid_o[i] = m_err_o[i];
      m_rdata_o[i] = ERR_RDATA;
      for (int j = 0; j <= NB_SLAVE; j++) m_gnt_o[i] = m_gnt_o[i] | (win[j][i] && hs[j]);
      for (int j = 0; j < NB_SLAVE; j++)
        if (pop[j] && head[j] == IW'(i)) begin
          m_rvalid_o[i] = 1'b1;
          m_rdata_o[i] = s_rdata_i[j];
        end
    end
  for (genvar j = 0; j < NB_SLAVE; j++) begin : g_fifo
    logic [IW-1:0] mem [MAX_OUTSTANDING];
    logic [PW-1:0] wp, rp;
    logic [CW-1:0] fc;
    logic idle;
    assign fcnt[j] = fc;
    assign s_idle_o[j] = idle;
    assign pop[j] = s_rvalid_i[j] && fc != '0;
    assign head[j] = mem[rp];
    always_ff @(posedge clk)
      if (hs[j]) mem[wp] <= widx[j];
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        fc <= '0;
        wp <= '0;
        rp <= '0;
        idle <= 1'b1;
      end else begin
        fc <= fc + CW'(hs[j]) - CW'(pop[j]);
        if (hs[j]) wp <= PW'((int'(wp) + 1) % MAX_OUTSTANDING);
        if (pop[j]) rp <= PW'((int'(rp) + 1) % MAX_OUTSTANDING);
        idle <= fc == '0 && !(|sreq[j]);
      end
    a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rst_n) s_rvalid_i[j] |-> fc != '0);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      cur <= '0;
      err_v <= 1'b0;
      err_id <= '0;
    end else begin
      for (int i = 0; i < NB_MASTER; i++) begin
        cnt[i] <= cnt[i] + CW'(m_gnt_o[i]) - CW'(m_rvalid_o[i]);
        if (m_gnt_o[i]) cur[i] <= tgt[i];
      end
      err_v <= hs[NB_SLAVE];
      err_id <= widx[NB_SLAVE];
    end
endmodule
